// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: BOOT -> FETCH -> HALT, retiring one instruction per acked, unstalled FETCH cycle.
// Next-PC, counter and state all update on the retiring edge; ack with stall holds everything.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_halt,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_instr_valid,
  output logic        o_halted,
  output logic        o_misalign,
  output logic [31:0] o_retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        misalign_q, misalign_d;
  logic        retire;
  logic        bad_target;

  assign retire     = (state_q == FETCH) && i_imem_ack && !i_stall;
  assign bad_target = i_br_taken && (i_br_target[1:0] != 2'b00);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      retired_q  <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    misalign_d = misalign_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (retire) begin
          // A misaligned redirect halts on the offending instruction without retiring it.
          if (bad_target) begin
            state_d    = HALT;
            misalign_d = 1'b1;
          end else if (i_halt) begin
            state_d   = HALT;
            retired_d = retired_q + 32'd1;
          end else if (i_br_taken) begin
            pc_d      = i_br_target;
            retired_d = retired_q + 32'd1;
          end else begin
            pc_d      = pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    o_imem_req    = (state_q == FETCH);
    o_instr_valid = (state_q == FETCH) && i_imem_ack;
    o_halted      = (state_q == HALT);
  end

  assign o_pc        = pc_q;
  assign o_imem_addr = pc_q;
  assign o_pc_four   = pc_q + 32'd4;
  assign o_misalign  = misalign_q;
  assign o_retired   = retired_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: default-reset instance for sequencing, a second
// instance reset near the top of the address space for the wrap case.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, ack, stall, br, halt;
  logic [31:0] tgt;
  logic        req, valid, halted, misalign;
  logic [31:0] addr, pc, pc_four, retired;

  logic        rst2, ack2, zero2;
  logic [31:0] zero_tgt2;
  logic        req2, valid2, halted2, misalign2;
  logic [31:0] addr2, pc2, pc_four2, retired2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack),
    .i_stall(stall), .i_br_taken(br), .i_br_target(tgt), .i_halt(halt),
    .o_pc(pc), .o_pc_four(pc_four), .o_instr_valid(valid),
    .o_halted(halted), .o_misalign(misalign), .o_retired(retired)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .i_clk(clk), .i_rst(rst2),
    .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_ack(ack2),
    .i_stall(zero2), .i_br_taken(zero2), .i_br_target(zero_tgt2), .i_halt(zero2),
    .o_pc(pc2), .o_pc_four(pc_four2), .o_instr_valid(valid2),
    .o_halted(halted2), .o_misalign(misalign2), .o_retired(retired2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " pc_four"}, pc_four, 32'h4);
    check({tag, " req"}, {31'd0, req}, 32'd0);
    check({tag, " valid"}, {31'd0, valid}, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " misalign"}, {31'd0, misalign}, 32'd0);
    check({tag, " retired"}, retired, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0; halt = 1'b0; tgt = 32'h0;
    rst2 = 1'b1; ack2 = 1'b0; zero2 = 1'b0; zero_tgt2 = 32'h0;

    tick(); rst = 1'b0; rst2 = 1'b0; settle();
    check_reset("boot");
    check("wrap reset pc", pc2, 32'hFFFF_FFF8);
    check("wrap reset req", {31'd0, req2}, 32'd0);

    tick(); ack = 1'b1; settle();
    check("fetch0 pc", pc, 32'h0);
    check("fetch0 addr", addr, 32'h0);
    check("fetch0 req", {31'd0, req}, 32'd1);
    check("fetch0 valid", {31'd0, valid}, 32'd1);

    tick(); settle();
    check("seq pc4", pc, 32'h4);
    check("seq ret1", retired, 32'd1);

    tick(); stall = 1'b1; br = 1'b1; tgt = 32'h100; settle();
    check("seq pc8", pc, 32'h8);
    check("seq ret2", retired, 32'd2);
    check("stall valid", {31'd0, valid}, 32'd1);

    tick(); settle();
    check("stall1 pc", pc, 32'h8);
    check("stall1 ret", retired, 32'd2);

    tick(); stall = 1'b0; br = 1'b0; settle();
    check("stall2 pc", pc, 32'h8);
    check("stall2 ret", retired, 32'd2);

    tick(); settle();
    check("post stall pc", pc, 32'hC);
    check("post stall ret", retired, 32'd3);

    tick(); br = 1'b1; tgt = 32'h40; settle();
    check("pc10", pc, 32'h10);
    check("ret4", retired, 32'd4);

    tick(); br = 1'b0; ack = 1'b0; settle();
    check("branch pc", pc, 32'h40);
    check("branch pc_four", pc_four, 32'h44);
    check("branch ret", retired, 32'd5);
    check("noack req", {31'd0, req}, 32'd1);
    check("noack valid", {31'd0, valid}, 32'd0);

    tick(); ack = 1'b1; br = 1'b1; tgt = 32'h46; settle();
    check("noack hold pc", pc, 32'h40);
    check("noack hold req", {31'd0, req}, 32'd1);

    tick(); br = 1'b0; settle();
    check("misal halted", {31'd0, halted}, 32'd1);
    check("misal flag", {31'd0, misalign}, 32'd1);
    check("misal pc", pc, 32'h40);
    check("misal ret", retired, 32'd5);
    check("misal req", {31'd0, req}, 32'd0);
    check("misal valid", {31'd0, valid}, 32'd0);

    tick(); rst = 1'b1; settle();
    check("halt ignore pc", pc, 32'h40);
    check("halt ignore flag", {31'd0, misalign}, 32'd1);

    tick(); rst = 1'b0; settle();
    check_reset("rst1");

    tick(); br = 1'b1; tgt = 32'h20; settle();
    check("refetch pc", pc, 32'h0);
    check("refetch req", {31'd0, req}, 32'd1);

    tick(); tgt = 32'h80; halt = 1'b1; settle();
    check("jump pc20", pc, 32'h20);
    check("jump ret", retired, 32'd1);

    tick(); halt = 1'b0; br = 1'b0; settle();
    check("halt halted", {31'd0, halted}, 32'd1);
    check("halt pc", pc, 32'h20);
    check("halt ret", retired, 32'd2);
    check("halt misalign", {31'd0, misalign}, 32'd0);
    check("halt req", {31'd0, req}, 32'd0);

    tick(); rst = 1'b1; settle();
    check("halt acks ignored pc", pc, 32'h20);
    check("halt acks ignored ret", retired, 32'd2);

    tick(); rst = 1'b0; ack = 1'b0; settle();
    check_reset("rst2");

    tick(); settle();
    check("after rst2 req", {31'd0, req}, 32'd1);
    check("after rst2 addr", addr, 32'h0);

    tick(); ack2 = 1'b1; settle();
    check("wrap pc0", pc2, 32'hFFFF_FFF8);
    check("wrap four0", pc_four2, 32'hFFFF_FFFC);

    tick(); settle();
    check("wrap pc1", pc2, 32'hFFFF_FFFC);
    check("wrap four1", pc_four2, 32'h0);

    tick(); ack2 = 1'b0; settle();
    check("wrap pc2", pc2, 32'h0);
    check("wrap addr2", addr2, 32'h0);
    check("wrap ret", retired2, 32'd2);
    check("wrap halted", {31'd0, halted2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter sequencer for the single-cycle RISC-V core. It owns the PC register and drives instruction-memory fetch requests with an ack handshake. On each retiring instruction it selects the next PC from PC+4, a taken-branch/jump target, or hold (stall). It also detects misaligned redirect targets, supports halt, and counts retired instructions. It sits between the instruction memory port and the decode/execute datapath, replacing a free-running PC+4 adder path.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_imem_req  out  1  fetch request to instruction memory.
- o_imem_addr  out  32  fetch address; always equals o_pc.
- i_imem_ack  in  1  instruction word available this cycle; ignored unless in FETCH.
- i_stall  in  1  datapath cannot accept instruction this cycle.
- i_br_taken  in  1  branch/jump taken for the current instruction.
- i_br_target  in  32  redirect target, valid with i_br_taken.
- i_halt  in  1  current instruction requests halt (ecall/ebreak).
- o_pc  out  32  current PC.
- o_pc_four  out  32  o_pc + 4, modulo 2^32.
- o_instr_valid  out  1  instruction at o_pc is being presented to the datapath.
- o_halted  out  1  controller is in HALT.
- o_misalign  out  1  sticky; halt was caused by a misaligned target.
- o_retired  out  32  count of retired instructions, wraps modulo 2^32.

## Operation
- States: BOOT, FETCH, HALT.
- BOOT:
  - o_imem_req=0.
  - Unconditionally goes to FETCH on the next edge.
- FETCH:
  - o_imem_req=1, o_imem_addr=o_pc.
  - o_instr_valid = i_imem_ack (combinational).
- Retire condition: FETCH & i_imem_ack & !i_stall.
- On retire, priority high to low:
  1. Misaligned redirect: i_br_taken & i_br_target[1:0]!=0.
     - Go to HALT; set o_misalign.
     - PC holds the offending instruction's address.
     - Instruction is not counted.
  2. i_halt:
     - Go to HALT; PC holds.
     - o_retired increments.
  3. i_br_taken:
     - PC <= i_br_target; o_retired increments.
  4. Otherwise:
     - PC <= o_pc_four; o_retired increments.
- FETCH with i_imem_ack & i_stall:
  - Nothing changes: PC, counter and state hold.
  - i_br_taken and i_halt are ignored.
  - The same address is re-presented next cycle.
- FETCH with no ack: hold; o_imem_req stays 1.
- HALT:
  - o_imem_req=0, o_halted=1.
  - All inputs ignored; only i_rst exits.
- Arithmetic:
  - o_pc_four is a 32-bit unsigned add; carry discarded.
  - 32'hFFFF_FFFC + 4 = 32'h0000_0000. PC wraps silently; wrap is not an error.
- Redirect targets are taken verbatim when aligned; bit 0 is not cleared.

## Timing
- Reset values:
  - state=BOOT, o_pc=RESET_PC, o_pc_four=RESET_PC+4.
  - o_imem_req=0, o_instr_valid=0, o_halted=0, o_misalign=0, o_retired=0.
- i_rst sampled high at an edge forces the reset values on that edge, from any state including mid-fetch and HALT. A pending ack in that cycle is discarded.
- First cycle after reset release: BOOT, req=0. Second cycle: FETCH, req=1, addr=RESET_PC.
- Latency:
  - PC update, counter increment and state change take effect on the edge that samples the retire condition.
  - New o_pc is visible in the next cycle.
  - Back-to-back single-cycle acks retire one instruction per cycle.
- o_instr_valid, o_imem_req, o_imem_addr, o_pc_four are combinational from registered state and i_imem_ack. There is no path from i_br_* or i_halt to o_imem_req or o_imem_addr.
- o_halted is asserted the cycle after the halting edge.
- o_misalign is asserted with o_halted and held until reset.

## Test plan
- Reset then 3 single-cycle acks, no branch -> o_pc sequence 0x0, 0x4, 0x8, 0xC; o_retired=3; req low only in BOOT cycle.
- At PC=0x8, ack with i_stall=1 for 2 cycles, then ack with i_stall=0 -> PC holds 0x8 across the stall and becomes 0xC after it; o_retired counts +1 only. A branch asserted during the stall is ignored.
- At PC=0x10, ack with i_br_taken=1, target 0x40 -> next o_pc=0x40, o_pc_four=0x44. Then target 0x46 -> HALT, o_misalign=1, o_pc=0x40, o_retired unchanged, req=0.
- RESET_PC=32'hFFFF_FFF8, two acks -> o_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; o_pc_four at 0xFFFF_FFFC is 0x0.
- Ack with i_halt=1 and i_br_taken=1 (aligned) at PC=0x20 -> HALT, o_pc=0x20, o_retired +1. Further acks ignored. Assert i_rst for one cycle mid-HALT -> all reset values, BOOT, then fetch from RESET_PC.
